btn_conditioner: RTL and testbench

Parametrised multi-channel push-button conditioner between the board button pins and the game control logic. For each channel it synchronises the raw pin, debounces it with a configurable hold time and delivers a clean level. It also produces one-cycle press and release events and, optionally, an auto-repeat event stream while a button is held, for example for continuous piece movement.

---
 rtl/btn_pkg.sv | 21 ++
 rtl/btn_channel.sv | 147 ++++++++++++++
 rtl/btn_conditioner.sv | 44 ++++
 tb/tb_btn_conditioner.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared types and width helper for the push-button conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Counter width able to hold values 0 .. max(a,b)-1
    function automatic int clog2_max(input int a, input int b);
        return $clog2((a > b) ? a : b);
    endfunction

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
// Module      : btn_channel
// Description : One button channel: 2-flop synchroniser, debounce, press /
//               release events and optional auto-repeat (BTN_AUTOREPEAT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module btn_channel
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = 1000000,
    parameter int REPEAT_DELAY  = 30000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_in,
    output logic pin_level,
    output logic pin_press,
    output logic pin_release,
    output logic pin_repeat
);

    localparam int              DB_W        = clog2_max(DB_CYCLES, DB_CYCLES);
    localparam logic [DB_W-1:0] c_db_last   = DB_W'(DB_CYCLES - 1);
    localparam logic            c_idle_pin  = (ACTIVE_LOW != 0);

    if (DB_CYCLES < 2) begin : g_bad_db
        $error("btn_channel: DB_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
        $error("btn_channel: REPEAT_DELAY and REPEAT_PERIOD must be at least 2");
    end

    logic [1:0]      r_sync;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic            w_in;
    logic            w_differ;
    logic            w_toggle;

    assign w_in     = r_sync[1] ^ c_idle_pin;
    assign w_differ = (w_in != r_level);
    assign w_toggle = w_differ && (r_db_cnt == c_db_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= {2{c_idle_pin}};
            r_db_cnt  <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], pin_in};
            if (!w_differ || w_toggle) begin
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
            if (w_toggle) begin
                r_level <= ~r_level;
            end
            r_press   <= w_toggle & ~r_level;
            r_release <= w_toggle & r_level;
        end
    end

    assign pin_level   = r_level;
    assign pin_press   = r_press;
    assign pin_release = r_release;

`ifdef BTN_AUTOREPEAT_EN
    localparam int                HOLD_W         = clog2_max(REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [HOLD_W-1:0] c_delay_last   = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] c_period_last  = HOLD_W'(REPEAT_PERIOD - 1);

    rpt_state_t        r_state;
    rpt_state_t        w_state_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              r_repeat;
    logic              w_repeat_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_hold   <= '0;
            r_repeat <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            r_repeat <= w_repeat_nxt;
        end
    end

    // Rise/fall use the debounce toggle so the FSM tracks the new level in the
    // same edge that pin_level changes.
    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold;
        w_repeat_nxt = 1'b0;
        if (w_toggle && r_level) begin
            w_state_nxt = IDLE;
            w_hold_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_toggle) begin
                        w_state_nxt = DELAY;
                        w_hold_nxt  = '0;
                    end
                end
                DELAY: begin
                    if (r_hold == c_delay_last) begin
                        w_repeat_nxt = 1'b1;
                        w_state_nxt  = REPEAT;
                        w_hold_nxt   = '0;
                    end else begin
                        w_hold_nxt = r_hold + HOLD_W'(1);
                    end
                end
                REPEAT: begin
                    if (r_hold == c_period_last) begin
                        w_repeat_nxt = 1'b1;
                        w_hold_nxt   = '0;
                    end else begin
                        w_hold_nxt = r_hold + HOLD_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    assign pin_repeat = r_repeat;
`else
    assign pin_repeat = 1'b0;
`endif

endmodule : btn_channel
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : btn_conditioner
// Description : PIN_NUM independent button channels; auto-repeat is built only
//               when BTN_AUTOREPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int PIN_NUM       = 3,
    parameter int DB_CYCLES     = 1000000,
    parameter int REPEAT_DELAY  = 30000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIN_NUM-1:0] pin_in,
    output logic [PIN_NUM-1:0] pin_level,
    output logic [PIN_NUM-1:0] pin_press,
    output logic [PIN_NUM-1:0] pin_release,
    output logic [PIN_NUM-1:0] pin_repeat
);

    for (genvar i = 0; i < PIN_NUM; i++) begin : g_chan
        btn_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .pin_in     (pin_in[i]),
            .pin_level  (pin_level[i]),
            .pin_press  (pin_press[i]),
            .pin_release(pin_release[i]),
            .pin_repeat (pin_repeat[i])
        );
    end

endmodule : btn_conditioner
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_conditioner
// Description : Directed + random bench for btn_conditioner, one active-high
//               and one active-low instance against a timing-rule model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

    localparam int NCH  = 3;
    localparam int DB   = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;
    localparam int MAXC = 4096;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] pin_h = '0;
    logic [NCH-1:0] pin_l = '1;
    logic [NCH-1:0] lvl_h, prs_h, rel_h, rep_h;
    logic [NCH-1:0] lvl_l, prs_l, rel_l, rep_l;

    always #5 clk = ~clk;

    btn_conditioner #(.PIN_NUM(NCH), .DB_CYCLES(DB), .REPEAT_DELAY(RD),
                      .REPEAT_PERIOD(RP), .ACTIVE_LOW(0)) dut_h (
        .clk(clk), .rst_n(rst_n), .pin_in(pin_h), .pin_level(lvl_h),
        .pin_press(prs_h), .pin_release(rel_h), .pin_repeat(rep_h));

    btn_conditioner #(.PIN_NUM(NCH), .DB_CYCLES(DB), .REPEAT_DELAY(RD),
                      .REPEAT_PERIOD(RP), .ACTIVE_LOW(1)) dut_l (
        .clk(clk), .rst_n(rst_n), .pin_in(pin_l), .pin_level(lvl_l),
        .pin_press(prs_l), .pin_release(rel_l), .pin_repeat(rep_l));

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: a level change happens once the synchronised input has differed
    // from the level for DB consecutive edges since the last change/reset.
    int             cyc = 0;
    bit             rstf [0:MAXC];
    bit             samp [2][NCH][0:MAXC];
    logic [NCH-1:0] e_lvl [2];
    logic [NCH-1:0] e_prs [2];
    logic [NCH-1:0] e_rel [2];
    logic [NCH-1:0] e_rep [2];
    int             last_tog [2][NCH];
    int             t_press  [2][NCH];
    bit             holding  [2][NCH];

    task automatic model_edge();
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got=%0d expected<%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        rstf[cyc] = !rst_n;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NCH; c++) begin
                bit pv;
                bit tog;
                bit lj;
                int d;
                pv = (k == 0) ? pin_h[c] : ~pin_l[c];
                e_prs[k][c] = 1'b0;
                e_rel[k][c] = 1'b0;
                e_rep[k][c] = 1'b0;
                if (!rst_n) begin
                    samp[k][c][cyc] = 1'b0;
                    e_lvl[k][c]     = 1'b0;
                    holding[k][c]   = 1'b0;
                    last_tog[k][c]  = cyc;
                end else begin
                    samp[k][c][cyc] = pv;
                    tog = ((cyc - last_tog[k][c]) >= DB);
                    for (int j = cyc - DB; j < cyc; j++) begin
                        lj = (j < 1 || rstf[j]) ? 1'b0 : samp[k][c][j-1];
                        if (lj == e_lvl[k][c]) tog = 1'b0;
                    end
                    if (tog) begin
                        if (e_lvl[k][c] == 1'b0) begin
                            e_prs[k][c]   = 1'b1;
                            holding[k][c] = 1'b1;
                            t_press[k][c] = cyc;
                        end else begin
                            e_rel[k][c]   = 1'b1;
                            holding[k][c] = 1'b0;
                        end
                        e_lvl[k][c]    = ~e_lvl[k][c];
                        last_tog[k][c] = cyc;
                    end
                    if (REP_EN && holding[k][c] && !e_prs[k][c]) begin
                        d = cyc - t_press[k][c];
                        if (d >= RD && ((d - RD) % RP) == 0) e_rep[k][c] = 1'b1;
                    end
                end
            end
        end
    endtask

    int n_prs [NCH];
    int n_rel [NCH];
    int n_rep [NCH];
    int n_hi  [NCH];
    int prs_cyc  [NCH];
    int rel_cyc  [NCH];
    int rep1_cyc [NCH];
    int n_prs_l2;

    task automatic clear_counts();
        for (int c = 0; c < NCH; c++) begin
            n_prs[c] = 0; n_rel[c] = 0; n_rep[c] = 0; n_hi[c] = 0;
            prs_cyc[c] = -1; rel_cyc[c] = -1; rep1_cyc[c] = -1;
        end
        n_prs_l2 = 0;
    endtask

    // One clock: model at posedge, compare at negedge, leave inputs to caller.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("level_h",   32'(lvl_h), 32'(e_lvl[0]));
        check("press_h",   32'(prs_h), 32'(e_prs[0]));
        check("release_h", 32'(rel_h), 32'(e_rel[0]));
        check("repeat_h",  32'(rep_h), 32'(e_rep[0]));
        check("level_l",   32'(lvl_l), 32'(e_lvl[1]));
        check("press_l",   32'(prs_l), 32'(e_prs[1]));
        check("release_l", 32'(rel_l), 32'(e_rel[1]));
        check("repeat_l",  32'(rep_l), 32'(e_rep[1]));
        for (int c = 0; c < NCH; c++) begin
            if (prs_h[c]) begin n_prs[c]++; prs_cyc[c] = cyc; end
            if (rel_h[c]) begin n_rel[c]++; rel_cyc[c] = cyc; end
            if (rep_h[c]) begin n_rep[c]++; if (rep1_cyc[c] < 0) rep1_cyc[c] = cyc; end
            if (lvl_h[c]) n_hi[c]++;
        end
        if (prs_l[2]) n_prs_l2++;
        #1;
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_h"}, 32'({lvl_h, prs_h, rel_h, rep_h}), 32'd0);
        check({tag, "_l"}, 32'({lvl_l, prs_l, rel_l, rep_l}), 32'd0);
    endtask

    int e1;
    int run_h [NCH];
    int run_l [NCH];

    initial begin
        clear_counts();
        repeat (3) step();
        check("reset_outputs", 32'({lvl_h, prs_h, rel_h, rep_h, lvl_l, prs_l, rel_l, rep_l}), 32'd0);
        rst_n = 1'b1;
        repeat (3) step();

        // Clean press on ch0, held 22 samples, then released
        clear_counts();
        pin_h[0] = 1'b1;
        e1 = cyc + 1;
        repeat (22) step();
        pin_h[0] = 1'b0;
        repeat (12) step();
        check("press_edge",   32'(prs_cyc[0] - e1 + 1), 32'(DB + 2));
        check("release_edge", 32'(rel_cyc[0] - (e1 + 22) + 1), 32'(DB + 2));
        check("press_count",  32'(n_prs[0]), 32'd1);
        check("repeat_count", 32'(n_rep[0]), REP_EN ? 32'd4 : 32'd0);
        check("other_ch_hi",  32'(n_hi[1] + n_hi[2]), 32'd0);

        // Glitches shorter than DB on ch1
        clear_counts();
        repeat (4) begin
            pin_h[1] = 1'b1;
            repeat (3) step();
            pin_h[1] = 1'b0;
            repeat (3) step();
        end
        repeat (6) step();
        check("glitch_hi",     32'(n_hi[1]), 32'd0);
        check("glitch_events", 32'(n_prs[1] + n_rel[1]), 32'd0);

        // Active-low channel 2
        clear_counts();
        pin_l[2] = 1'b0;
        repeat (10) step();
        check("al_press_count", 32'(n_prs_l2), 32'd1);
        pin_l[2] = 1'b1;
        repeat (10) step();

        // Reset while ch0 is in REPEAT, button still held afterwards
        pin_h[0] = 1'b1;
        repeat (20) step();
        async_reset("mid_repeat_rst");
        repeat (2) step();
        rst_n = 1'b1;
        clear_counts();
        e1 = cyc;
        repeat (20) step();
        check("rst_press_edge", 32'(prs_cyc[0] - e1), 32'(DB + 2));
        check("rst_repeat_cnt", 32'(n_rep[0]), REP_EN ? 32'd2 : 32'd0);
        if (REP_EN)
            check("rst_first_rep", 32'(rep1_cyc[0] - prs_cyc[0]), 32'(RD));
        pin_h[0] = 1'b0;
        repeat (12) step();

        // Random runs on every channel of both instances
        for (int c = 0; c < NCH; c++) begin
            run_h[c] = 0;
            run_l[c] = 0;
        end
        for (int n = 0; n < 1800; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if (run_h[c] == 0) begin
                    pin_h[c] = ~pin_h[c];
                    run_h[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45)
                                                           : $urandom_range(1, 8);
                end
                run_h[c]--;
                if (run_l[c] == 0) begin
                    pin_l[c] = ~pin_l[c];
                    run_l[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45)
                                                           : $urandom_range(1, 8);
                end
                run_l[c]--;
            end
            if (n == 900) begin
                async_reset("random_rst");
                repeat (2) step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_btn_conditioner
`default_nettype wire
